// File: rtl/wb_cmd_master.sv
// ---------------------------------------------------------------------------
// wb_cmd_master
//
// Converts a valid/ready command stream into single classic Wishbone
// transactions, one in flight at a time, and returns the result on a
// valid/ready response channel. A transaction that sees neither ack nor err
// within TIMEOUT bus cycles is abandoned and reported as a timeout.
//
// Parameters
//   TIMEOUT        bus cycles to wait for ack/err before abort (2..65535)
//
// Ports
//   clk            sole clock, rising edge
//   reset          asynchronous, active-low reset
//   cmd_*          command channel (valid/ready, we, 30-bit word address,
//                  32-bit write data, 4-bit byte select)
//   rsp_*          response channel (valid/ready, read data, err, timeout)
//   wishbone_*     Wishbone master signals (classic cycles, cti/bte fixed 0)
//
// Optional feature
//   WB_CMD_MASTER_STATS_EN  when defined, adds saturating 16-bit counters
//                           stat_txn / stat_err / stat_tmo, bumped on every
//                           response (total / error / timeout).
// ---------------------------------------------------------------------------
module wb_cmd_master #(
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        reset,
  // command channel
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [29:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  // response channel
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        rsp_timeout,
  // wishbone master
  output logic [29:0] wishbone_adr,
  output logic [31:0] wishbone_datwr,
  output logic [3:0]  wishbone_sel,
  output logic        wishbone_cyc,
  output logic        wishbone_stb,
  output logic        wishbone_we,
  output logic [2:0]  wishbone_cti,
  output logic [1:0]  wishbone_bte,
  input  logic [31:0] wishbone_datrd,
  input  logic        wishbone_ack,
  input  logic        wishbone_err
`ifdef WB_CMD_MASTER_STATS_EN
  ,
  output logic [15:0] stat_txn,
  output logic [15:0] stat_err,
  output logic [15:0] stat_tmo
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Counter value on the edge at which it would reach TIMEOUT.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  logic [1:0]  state_q,     state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        we_q,        we_d;
  logic [29:0] adr_q,       adr_d;
  logic [31:0] dat_q,       dat_d;
  logic [3:0]  sel_q,       sel_d;
  logic [15:0] cnt_q,       cnt_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_dat_q,   rsp_dat_d;
  logic        rsp_err_q,   rsp_err_d;
  logic        rsp_tmo_q,   rsp_tmo_d;
  logic        resp_enter;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    rsp_tmo_d   = rsp_tmo_q;

    case (state_q)
      ST_IDLE: begin
        // cmd_ready_q (not the state) gates acceptance so that nothing is
        // taken on the first edge after reset release.
        if (cmd_valid && cmd_ready_q) begin
          we_d    = cmd_we;
          adr_d   = cmd_adr;
          dat_d   = cmd_dat;
          sel_d   = cmd_sel;
          cnt_d   = 16'd0;
          state_d = ST_BUS;
        end
      end

      ST_BUS: begin
        cnt_d = cnt_q + 16'd1;
        // Priority: err over ack, and either over the timeout.
        if (wishbone_err) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = 32'h0;
          rsp_err_d   = 1'b1;
          rsp_tmo_d   = 1'b0;
        end else if (wishbone_ack) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = we_q ? 32'h0 : wishbone_datrd;
          rsp_err_d   = 1'b0;
          rsp_tmo_d   = 1'b0;
        end else if (cnt_q == TMO_LAST) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = 32'h0;
          rsp_err_d   = 1'b0;
          rsp_tmo_d   = 1'b1;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
    resp_enter  = (state_q == ST_BUS) && (state_d == ST_RESP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      rsp_tmo_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of every other flop.
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      rsp_tmo_q   <= rsp_tmo_d;
    end
  end

  // cyc/stb decode straight from the state flop so an asynchronous reset
  // drops them without waiting for a clock edge.
  assign wishbone_cyc   = (state_q == ST_BUS);
  assign wishbone_stb   = (state_q == ST_BUS);
  assign wishbone_we    = we_q;
  assign wishbone_adr   = adr_q;
  assign wishbone_datwr = dat_q;
  assign wishbone_sel   = sel_q;
  assign wishbone_cti   = 3'b000;
  assign wishbone_bte   = 2'b00;

  assign cmd_ready      = cmd_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_dat        = rsp_dat_q;
  assign rsp_err        = rsp_err_q;
  assign rsp_timeout    = rsp_tmo_q;

`ifdef WB_CMD_MASTER_STATS_EN
  logic [15:0] stat_txn_q, stat_txn_d;
  logic [15:0] stat_err_q, stat_err_d;
  logic [15:0] stat_tmo_q, stat_tmo_d;

  always_comb begin
    stat_txn_d = stat_txn_q;
    stat_err_d = stat_err_q;
    stat_tmo_d = stat_tmo_q;
    if (resp_enter) begin
      if (stat_txn_q != 16'hFFFF) stat_txn_d = stat_txn_q + 16'd1;
      if (rsp_err_d && (stat_err_q != 16'hFFFF)) stat_err_d = stat_err_q + 16'd1;
      if (rsp_tmo_d && (stat_tmo_q != 16'hFFFF)) stat_tmo_d = stat_tmo_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_txn_q <= '0;
      stat_err_q <= '0;
      stat_tmo_q <= '0;
    end else begin
      stat_txn_q <= stat_txn_d;
      stat_err_q <= stat_err_d;
      stat_tmo_q <= stat_tmo_d;
    end
  end

  assign stat_txn = stat_txn_q;
  assign stat_err = stat_err_q;
  assign stat_tmo = stat_tmo_q;
`else
  // Without the statistics option resp_enter has no consumer.
  logic unused_resp_enter;
  assign unused_resp_enter = resp_enter;
`endif

endmodule
